// File: rtl/textlcd_rx.sv
`default_nettype none
// ============================================================================
// Module   : textlcd_rx
// Brief    : Character-LCD bus receiver. Oversamples E/RS/RW/DATA, decodes
//            HD44780 writes and keeps a 2x16 character mirror plus mode bits.
// Revision : 1.0 - initial release
// ============================================================================
module textlcd_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic [6:0] ddram_addr,
    output logic       entry_inc,
    output logic       disp_on,
    output logic       two_line,
    output logic       busy,
    output logic       wr_strobe,
    output logic       overrun,
    output logic       read_req
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    // Bus bundle layout: {e, rs, rw, data[7:0]}
    logic [10:0] r_sync [SYNC_STAGES];
    logic [10:0] w_smp;
    logic [10:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) r_sync[0] <= '0;
        else       r_sync[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) r_sync[gi] <= '0;
                else       r_sync[gi] <= r_sync[gi-1];
            end
        end
    endgenerate

    assign w_smp = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) r_prev <= '0;
        else       r_prev <= w_smp;
    end

    // Transfer on falling E; fields come from the last sample with E high.
    logic       w_xfer;
    logic       w_rs;
    logic       w_rw;
    logic [7:0] w_d;

    assign w_xfer = r_prev[10] & ~w_smp[10];
    assign w_rs   = r_prev[9];
    assign w_rw   = r_prev[8];
    assign w_d    = r_prev[7:0];

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [4:0] r_k;
    logic       w_start_clear;

    assign busy          = (r_state == c_ST_CLEAR);
    assign w_start_clear = w_xfer & ~w_rw & ~w_rs & ~busy & (w_d == 8'h01);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start_clear) w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: if (r_k == 5'd31)  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)              r_k <= 5'd0;
        else if (w_start_clear) r_k <= 5'd0;
        else if (busy)          r_k <= r_k + 5'd1;
    end

    // Address advance with the HD44780 two-line wrap points.
    logic [6:0] w_addr_nxt;

    always_comb begin
        w_addr_nxt = ddram_addr;
        if (entry_inc) begin
            if      (ddram_addr == 7'h27) w_addr_nxt = 7'h40;
            else if (ddram_addr == 7'h67) w_addr_nxt = 7'h00;
            else                          w_addr_nxt = ddram_addr + 7'd1;
        end else begin
            if      (ddram_addr == 7'h00) w_addr_nxt = 7'h67;
            else if (ddram_addr == 7'h40) w_addr_nxt = 7'h27;
            else                          w_addr_nxt = ddram_addr - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ddram_addr <= 7'h00;
            entry_inc  <= 1'b1;
            disp_on    <= 1'b0;
            two_line   <= 1'b0;
            wr_strobe  <= 1'b0;
            overrun    <= 1'b0;
            read_req   <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            overrun   <= 1'b0;
            read_req  <= 1'b0;
            if (w_xfer) begin
                if (w_rw) begin
                    read_req <= 1'b1;
                end else if (busy) begin
                    overrun <= 1'b1;
                end else begin
                    wr_strobe <= 1'b1;
                    if (w_rs) begin
                        ddram_addr <= w_addr_nxt;
                    end else begin
                        casez (w_d)
                            8'b1???????: ddram_addr <= w_d[6:0];
                            8'b01??????: ;
                            8'b001?????: two_line   <= w_d[3];
                            8'b0001????: ;
                            8'b00001???: disp_on    <= w_d[2];
                            8'b000001??: entry_inc  <= w_d[1];
                            8'b0000001?: ddram_addr <= 7'h00;
                            8'b00000001: begin
                                ddram_addr <= 7'h00;
                                entry_inc  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Single write port: clear sweep and data writes never overlap.
    logic [7:0] r_mem [32];
    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = 5'd0;
        w_wdata = CLEAR_CHAR;
        if (busy) begin
            w_we    = 1'b1;
            w_waddr = r_k;
            w_wdata = CLEAR_CHAR;
        end else if (w_xfer && !w_rw && w_rs && (ddram_addr[5:4] == 2'b00)) begin
            w_we    = 1'b1;
            w_waddr = {ddram_addr[6], ddram_addr[3:0]};
            w_wdata = w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= CLEAR_CHAR;
            rd_char <= CLEAR_CHAR;
        end else begin
            rd_char <= r_mem[rd_idx];
            if (w_we) r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_textlcd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_textlcd_rx
// Brief    : Directed self-checking bench for textlcd_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_textlcd_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;
    logic [6:0] ddram_addr;
    logic       entry_inc;
    logic       disp_on;
    logic       two_line;
    logic       busy;
    logic       wr_strobe;
    logic       overrun;
    logic       read_req;

    int errors = 0;
    int checks = 0;
    int n_wr   = 0;
    int n_ovr  = 0;
    int n_rd   = 0;
    int n_busy = 0;

    textlcd_rx #(.SYNC_STAGES(2), .CLEAR_CHAR(8'h20)) dut (
        .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data(lcd_data), .rd_idx(rd_idx),
        .rd_char(rd_char), .ddram_addr(ddram_addr), .entry_inc(entry_inc),
        .disp_on(disp_on), .two_line(two_line), .busy(busy),
        .wr_strobe(wr_strobe), .overrun(overrun), .read_req(read_req)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) n_wr++;
        if (overrun)   n_ovr++;
        if (read_req)  n_rd++;
        if (busy)      n_busy++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) bus_xfer(1'b1, 1'b0, s[i]);
    endtask

    task automatic read_mem(input int idx, output logic [7:0] v);
        @(negedge clk);
        rd_idx = idx[4:0];
        @(negedge clk);
        v = rd_char;
    endtask

    task automatic test_reset;
        reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data = 8'h00; rd_idx = 5'd0;
        repeat (3) @(negedge clk);
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h required 00", ddram_addr); end
        checks++; if ({entry_inc, disp_on, two_line, busy} !== 4'b1000) begin errors++; $display("FAIL reset_mode: got %b required 1000", {entry_inc, disp_on, two_line, busy}); end
        checks++; if ({wr_strobe, overrun, read_req} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b required 000", {wr_strobe, overrun, read_req}); end
        checks++; if (rd_char !== 8'h20) begin errors++; $display("FAIL reset_rdchar: got %h required 20", rd_char); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_init;
        int w0;
        w0 = n_wr;
        bus_xfer(1'b0, 1'b0, 8'h38);
        bus_xfer(1'b0, 1'b0, 8'h0C);
        bus_xfer(1'b0, 1'b0, 8'h06);
        checks++; if ({two_line, disp_on, entry_inc} !== 3'b111) begin errors++; $display("FAIL init_mode: got %b required 111", {two_line, disp_on, entry_inc}); end
        checks++; if (n_wr - w0 !== 3) begin errors++; $display("FAIL init_strobes: got %0d required 3", n_wr - w0); end
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL init_addr: got %h required 00", ddram_addr); end
    endtask

    task automatic test_text;
        string      exp;
        logic [7:0] v;
        int         bad;
        exp = "digital system  ";
        bus_xfer(1'b0, 1'b0, 8'h80);
        put_str("digital system      ");
        checks++; if (ddram_addr !== 7'h14) begin errors++; $display("FAIL text_addr: got %h required 14", ddram_addr); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            read_mem(i, v);
            if (v !== exp[i]) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL text_line1: got %0d wrong entries required 0", bad); end
        bad = 0;
        for (int i = 16; i < 20; i++) begin
            read_mem(i, v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL text_discard: got %0d wrong entries required 0", bad); end
    endtask

    task automatic test_line2;
        string      exp;
        logic [7:0] v;
        int         bad;
        exp = "hello world!";
        bus_xfer(1'b0, 1'b0, 8'hC0);
        put_str(exp);
        checks++; if (ddram_addr !== 7'h4C) begin errors++; $display("FAIL line2_addr: got %h required 4c", ddram_addr); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            read_mem(16 + i, v);
            if (v !== exp[i]) bad++;
        end
        read_mem(28, v);
        if (v !== 8'h20) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL line2_text: got %0d wrong entries required 0", bad); end
        bus_xfer(1'b0, 1'b0, 8'h02);
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL home_addr: got %h required 00", ddram_addr); end
        read_mem(0, v);
        checks++; if (v !== 8'h64) begin errors++; $display("FAIL home_keep0: got %h required 64", v); end
        read_mem(16, v);
        checks++; if (v !== 8'h68) begin errors++; $display("FAIL home_keep16: got %h required 68", v); end
    endtask

    task automatic test_clear;
        int         w0, o0, b0, bad;
        logic [7:0] v;
        w0 = n_wr; o0 = n_ovr; b0 = n_busy;
        bus_xfer(1'b0, 1'b0, 8'h01);
        bus_xfer(1'b1, 1'b0, 8'h51);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_timeout: got busy=%b required 0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (n_busy - b0 !== 32) begin errors++; $display("FAIL clear_busy_len: got %0d required 32", n_busy - b0); end
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL clear_overrun: got %0d required 1", n_ovr - o0); end
        checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL clear_strobes: got %0d required 1", n_wr - w0); end
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL clear_addr: got %h required 00", ddram_addr); end
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            read_mem(i, v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL clear_fill: got %0d wrong entries required 0", bad); end
    endtask

    task automatic test_entry_wrap;
        logic [7:0] v;
        int         w0, r0;
        bus_xfer(1'b0, 1'b0, 8'h04);
        checks++; if (entry_inc !== 1'b0) begin errors++; $display("FAIL entry_dec: got %b required 0", entry_inc); end
        bus_xfer(1'b0, 1'b0, 8'h80);
        bus_xfer(1'b1, 1'b0, 8'h41);
        checks++; if (ddram_addr !== 7'h67) begin errors++; $display("FAIL wrap_dec00: got %h required 67", ddram_addr); end
        read_mem(0, v);
        checks++; if (v !== 8'h41) begin errors++; $display("FAIL wrap_charA: got %h required 41", v); end
        bus_xfer(1'b0, 1'b0, 8'hC0);
        bus_xfer(1'b1, 1'b0, 8'h44);
        checks++; if (ddram_addr !== 7'h27) begin errors++; $display("FAIL wrap_dec40: got %h required 27", ddram_addr); end
        read_mem(16, v);
        checks++; if (v !== 8'h44) begin errors++; $display("FAIL wrap_charD: got %h required 44", v); end
        bus_xfer(1'b0, 1'b0, 8'h06);
        bus_xfer(1'b0, 1'b0, 8'hA7);
        bus_xfer(1'b1, 1'b0, 8'h42);
        checks++; if (ddram_addr !== 7'h40) begin errors++; $display("FAIL wrap_inc27: got %h required 40", ddram_addr); end
        bus_xfer(1'b0, 1'b0, 8'hE7);
        bus_xfer(1'b1, 1'b0, 8'h43);
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL wrap_inc67: got %h required 00", ddram_addr); end
        read_mem(16, v);
        checks++; if (v !== 8'h44) begin errors++; $display("FAIL wrap_discard: got %h required 44", v); end
        bus_xfer(1'b0, 1'b0, 8'hFF);
        bus_xfer(1'b1, 1'b0, 8'h45);
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL wrap_inc7f: got %h required 00", ddram_addr); end
        w0 = n_wr; r0 = n_rd;
        bus_xfer(1'b1, 1'b1, 8'h55);
        checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL read_req_cnt: got %0d required 1", n_rd - r0); end
        checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL read_no_strobe: got %0d required 0", n_wr - w0); end
        checks++; if (ddram_addr !== 7'h00) begin errors++; $display("FAIL read_no_addr: got %h required 00", ddram_addr); end
    endtask

    task automatic test_reset_in_clear;
        logic [7:0] v;
        int         bad;
        bus_xfer(1'b0, 1'b0, 8'h80);
        put_str("XXXXXXXXXXXXXXXX");
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstclr_start: got busy=%b required 1", busy); end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstclr_busy: got %b required 0", busy); end
        checks++; if ({disp_on, entry_inc, two_line} !== 3'b010) begin errors++; $display("FAIL rstclr_mode: got %b required 010", {disp_on, entry_inc, two_line}); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            read_mem(i, v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstclr_fill: got %0d wrong entries required 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstclr_stays_idle: got %b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_text();
        test_line2();
        test_clear();
        test_entry_wrap();
        test_reset_in_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
